// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard / branch-resolution controller.
// The controller binds the slave modport; the pipeline (or a bench) drives via master.
interface branch_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] rsD;
  logic [REG_W-1:0] rtD;
  logic [REG_W-1:0] rsE;
  logic [REG_W-1:0] rtE;
  logic [REG_W-1:0] writeregE;
  logic [REG_W-1:0] writeregM;
  logic [REG_W-1:0] writeregW;
  logic             regwriteE;
  logic             regwriteM;
  logic             regwriteW;
  logic             memtoregE;
  logic             memtoregM;
  logic             branchD;
  logic             bneD;
  logic [31:0]      compout;

  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic             flushD;
  logic             pcsrcD;
  logic             forwardAD;
  logic             forwardBD;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, bneD, compout,
    input  stallF, stallD, flushE, flushD, pcsrcD,
    input  forwardAD, forwardBD, forwardAE, forwardBE, stall_cnt, flush_cnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, bneD, compout,
    output stallF, stallD, flushE, flushD, pcsrcD,
    output forwardAD, forwardBD, forwardAE, forwardBE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Hazard and branch-resolution controller for a 5-stage MIPS pipeline.
// Produces stall/flush/forward controls, the branch PC-source select, and
// saturating debug counters of stall and flush events.
module branch_hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = 5
) (
  input logic                 clk,
  input logic                 reset,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Register 0 is hard-wired zero, so it never carries a real dependency.
  function automatic logic f_match(input logic             rw,
                                   input logic [REG_W-1:0] wr,
                                   input logic [REG_W-1:0] src);
    return rw && (wr == src) && (src != '0);
  endfunction

  logic w_rsD_E, w_rtD_E, w_rsD_M, w_rtD_M;
  logic w_rsE_M, w_rsE_W, w_rtE_M, w_rtE_W;
  logic w_lw_det, w_br_det, w_ld_br;
  logic w_stall, w_taken, w_pcsrc;
  logic w_unused;

  assign w_rsD_E = f_match(bus.regwriteE, bus.writeregE, bus.rsD);
  assign w_rtD_E = f_match(bus.regwriteE, bus.writeregE, bus.rtD);
  assign w_rsD_M = f_match(bus.regwriteM, bus.writeregM, bus.rsD);
  assign w_rtD_M = f_match(bus.regwriteM, bus.writeregM, bus.rtD);
  assign w_rsE_M = f_match(bus.regwriteM, bus.writeregM, bus.rsE);
  assign w_rsE_W = f_match(bus.regwriteW, bus.writeregW, bus.rsE);
  assign w_rtE_M = f_match(bus.regwriteM, bus.writeregM, bus.rtE);
  assign w_rtE_W = f_match(bus.regwriteW, bus.writeregW, bus.rtE);

  // Only the equality flag of the comparator result is meaningful.
  assign w_unused = ^bus.compout[31:1];

  // Forwarding selects: MEM result beats WB; keep working through reset.
  always_comb begin
    bus.forwardAE = 2'b00;
    bus.forwardBE = 2'b00;
    if (w_rsE_M)      bus.forwardAE = 2'b10;
    else if (w_rsE_W) bus.forwardAE = 2'b01;
    if (w_rtE_M)      bus.forwardBE = 2'b10;
    else if (w_rtE_W) bus.forwardBE = 2'b01;
    // A load in MEM has no ALU result yet, so ID cannot forward from it.
    bus.forwardAD = w_rsD_M & ~bus.memtoregM;
    bus.forwardBD = w_rtD_M & ~bus.memtoregM;
  end

  // Hazard detection and branch resolution; a stall suppresses the redirect.
  always_comb begin
    w_lw_det = bus.memtoregE & (w_rsD_E | w_rtD_E);
    w_br_det = bus.branchD & ((w_rsD_E | w_rtD_E) | (bus.memtoregM & (w_rsD_M | w_rtD_M)));
    w_ld_br  = bus.branchD & bus.memtoregE & (w_rsD_E | w_rtD_E);
    w_stall  = (r_state == StHold) | w_lw_det | w_br_det;
    w_taken  = bus.bneD ? ~bus.compout[0] : bus.compout[0];
    w_pcsrc  = bus.branchD & w_taken & ~w_stall;
  end

  // Control outputs are forced quiet while reset is held.
  assign bus.stallF    = w_stall & ~reset;
  assign bus.stallD    = w_stall & ~reset;
  assign bus.flushE    = w_stall & ~reset;
  assign bus.pcsrcD    = w_pcsrc & ~reset;
  assign bus.flushD    = w_pcsrc & ~reset;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // Load-to-branch needs a second bubble: HOLD stalls for exactly one extra cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle:  r_state <= w_ld_br ? StHold : StIdle;
        StHold:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Saturating debug counters of stall and flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CntMax)) r_stall_cnt <= r_stall_cnt + CntOne;
      if (w_pcsrc && (r_flush_cnt != CntMax)) r_flush_cnt <= r_flush_cnt + CntOne;
    end
  end

endmodule
